// File: rtl/ram_block_reader.sv
// Burst read engine for a registered (1-cycle latency) RAM read port.
// Issues sequential reads and returns the words on a valid/ready stream through a 2-entry skid FIFO.
module ram_block_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_output_enable,
   output logic [ADDR_WIDTH-1:0] ram_address,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [DATA_WIDTH-1:0] stream_data,
   output logic                  stream_valid,
   input  logic                  stream_ready,
   output logic                  stream_last
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic [DATA_WIDTH-1:0] r_fifo_data [2];
   logic [1:0]            r_fifo_last;
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_issue;
   logic [2:0]            w_occupancy;

   assign w_push      = r_inflight;
   assign w_pop       = stream_valid && stream_ready;
   // Slots already claimed once this cycle's pop is accounted for.
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue     = (r_state == S_RUN) && (r_remaining != '0) && (w_occupancy < 3'd2);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (length == '0) ? S_FINISH : S_RUN;
            end
         end
         S_RUN: begin
            if ((r_remaining == '0) && !r_inflight &&
                ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr          <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_fifo_last     <= '0;
         r_rd_ptr        <= 1'b0;
         r_wr_ptr        <= 1'b0;
         r_count         <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_addr      <= base_address;
            r_remaining <= length;
         end else if (w_issue) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
         end
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_remaining == LEN_ONE);
         if (w_push) begin
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Payload storage needs no reset: the valid count alone qualifies it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= ram_data_out;
      end
   end

   assign busy              = (r_state == S_RUN);
   assign done              = (r_state == S_FINISH);
   assign ram_output_enable = w_issue;
   assign ram_address       = r_addr;
   assign stream_valid      = (r_count != 2'd0);
   assign stream_data       = stream_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign stream_last       = stream_valid && r_fifo_last[r_rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_push && !w_pop && (r_count == 2'd2)));
   a_strobe_in_run: assert property (@(posedge clk) disable iff (reset)
      !(ram_output_enable && (r_state != S_RUN)));

endmodule

// File: tb/tb_ram_block_reader.sv
// Randomized bench for ram_block_reader: a registered RAM model feeds the DUT and each burst
// is compared against a queue-level expectation built directly from the RAM contents.
module tb_ram_block_reader;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LW = AW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_address;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic          ram_output_enable;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_out = '0;
   logic [DW-1:0] stream_data;
   logic          stream_valid;
   logic          stream_ready;
   logic          stream_last;

   logic [DW-1:0] mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] got_data [$];
   logic          got_last [$];
   logic [AW-1:0] got_addr [$];
   int            acc_k    [$];
   int            done_count, done_k, first_valid_k, first_strobe_k;
   int            max_ahead, stall_changes, timed_out;
   logic          busy_at_done;

   ram_block_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_address      (base_address),
      .length            (length),
      .busy              (busy),
      .done              (done),
      .ram_output_enable (ram_output_enable),
      .ram_address       (ram_address),
      .ram_data_out      (ram_data_out),
      .stream_data       (stream_data),
      .stream_valid      (stream_valid),
      .stream_ready      (stream_ready),
      .stream_last       (stream_last)
   );

   always #5 clk = ~clk;

   // Port B of the RAM: registered read, one cycle of latency.
   always @(posedge clk) begin
      if (ram_output_enable) ram_data_out <= mem[ram_address];
   end

   // Drives one burst and records what the DUT did; k counts samples after the start edge.
   task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode, input int restart_k);
      int k, issued, accepted, budget;
      logic stalled, sl;
      logic [DW-1:0] sd;
      got_data.delete(); got_last.delete(); got_addr.delete(); acc_k.delete();
      done_count = 0; done_k = -1; first_valid_k = -1; first_strobe_k = -1;
      max_ahead = 0; stall_changes = 0; timed_out = 0; busy_at_done = 1'b1;
      k = 0; issued = 0; accepted = 0; stalled = 1'b0; sd = '0; sl = 1'b0;
      budget = len * 4 + 20;
      base_address = b; length = LW'(len); start = 1'b1;
      forever begin
         @(posedge clk); #1;
         start        = (k == restart_k);
         base_address = (k == restart_k) ? ~b : b;
         length       = (k == restart_k) ? LW'(2) : LW'(len);
         if (mode == 0)      stream_ready = 1'b1;
         else if (mode == 1) stream_ready = (k % 2 == 0);
         else                stream_ready = 1'($urandom_range(0, 1));
         #1;
         if (ram_output_enable) begin
            got_addr.push_back(ram_address);
            issued++;
            if (first_strobe_k < 0) first_strobe_k = k;
         end
         if (stream_valid && first_valid_k < 0) first_valid_k = k;
         if (stalled && (!stream_valid || stream_data !== sd || stream_last !== sl)) stall_changes++;
         if (stream_valid && stream_ready) begin
            got_data.push_back(stream_data);
            got_last.push_back(stream_last);
            acc_k.push_back(k);
            accepted++;
         end
         stalled = stream_valid && !stream_ready;
         sd = stream_data; sl = stream_last;
         if (issued - accepted > max_ahead) max_ahead = issued - accepted;
         if (done) begin
            done_count++;
            if (done_k < 0) begin done_k = k; busy_at_done = busy; end
         end
         k++;
         if (done_k >= 0 && k > done_k + 2) break;
         if (k > budget) begin timed_out = 1; break; end
      end
      start = 1'b0; stream_ready = 1'b0; base_address = b;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; stream_ready = 1'b0; base_address = '0; length = '0;
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last} !== '0)
         $display("FAIL reset_initial: outputs=%0h want 0",
                  {busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, stream_valid} !== 3'b000) $display("FAIL reset_release: busy/done/valid=%b want 000", {busy, done, stream_valid});
      else n_pass++;
      base_address = 8'd40; length = LW'(5); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL reset_pre_busy: busy=%b want 1", busy);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last} !== '0)
         $display("FAIL reset_async: outputs=%0h want 0",
                  {busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last});
      else n_pass++;
      @(posedge clk); #1 reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_idle: busy/done=%b want 00", {busy, done});
      else n_pass++;
   endtask

   task automatic test_basic(input string tag);
      logic [AW-1:0] b;
      b = 8'd40;
      run_burst(b, 5, 0, -1);
      n_checks++;
      if (timed_out != 0) $display("FAIL %s_timeout: timed out", tag); else n_pass++;
      n_checks++;
      if (got_data.size() != 5) $display("FAIL %s_count: beats=%0d want 5", tag, got_data.size()); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({got_last[i], got_data[i]} !== {(i == 4), mem[8'(b + i)]})
            $display("FAIL %s_beat%0d: last/data=%b/%0h want %b/%0h", tag, i, got_last[i], got_data[i], (i == 4), mem[8'(b + i)]);
         else n_pass++;
         n_checks++;
         if (acc_k[i] != 2 + i) $display("FAIL %s_accept_cycle%0d: got %0d want %0d", tag, i, acc_k[i], 2 + i);
         else n_pass++;
         n_checks++;
         if (got_addr[i] !== 8'(b + i)) $display("FAIL %s_addr%0d: got %0d want %0d", tag, i, got_addr[i], 8'(b + i));
         else n_pass++;
      end
      n_checks++;
      if (first_strobe_k != 0) $display("FAIL %s_first_strobe: cycle %0d want 0", tag, first_strobe_k); else n_pass++;
      n_checks++;
      if (first_valid_k != 2) $display("FAIL %s_first_valid: cycle %0d want 2", tag, first_valid_k); else n_pass++;
      n_checks++;
      if (done_count != 1 || done_k != 7) $display("FAIL %s_done: count=%0d cycle=%0d want 1/7", tag, done_count, done_k);
      else n_pass++;
      n_checks++;
      if (busy_at_done !== 1'b0) $display("FAIL %s_busy_at_done: busy=%b want 0", tag, busy_at_done); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] b;
      b = 8'd40;
      run_burst(b, 5, 1, -1);
      n_checks++;
      if (got_data.size() != 5 || timed_out != 0) $display("FAIL bp_count: beats=%0d timeout=%0d want 5/0", got_data.size(), timed_out);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({got_last[i], got_data[i]} !== {(i == 4), mem[8'(b + i)]})
            $display("FAIL bp_beat%0d: last/data=%b/%0h want %b/%0h", i, got_last[i], got_data[i], (i == 4), mem[8'(b + i)]);
         else n_pass++;
      end
      n_checks++;
      if (stall_changes != 0) $display("FAIL bp_stall_stable: changes=%0d want 0", stall_changes); else n_pass++;
      n_checks++;
      if (max_ahead > 2) $display("FAIL bp_ahead: strobes ahead=%0d want <=2", max_ahead); else n_pass++;
      n_checks++;
      if (done_count != 1 || done_k != acc_k[4] + 1)
         $display("FAIL bp_done: count=%0d cycle=%0d want 1/%0d", done_count, done_k, acc_k[4] + 1);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [AW-1:0] b;
      b = 8'd254;
      run_burst(b, 4, 2, -1);
      n_checks++;
      if (got_addr.size() != 4 || got_data.size() != 4)
         $display("FAIL wrap_count: strobes=%0d beats=%0d want 4/4", got_addr.size(), got_data.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (got_addr[i] !== 8'(b + i)) $display("FAIL wrap_addr%0d: got %0d want %0d", i, got_addr[i], 8'(b + i));
         else n_pass++;
         n_checks++;
         if ({got_last[i], got_data[i]} !== {(i == 3), mem[8'(b + i)]})
            $display("FAIL wrap_beat%0d: last/data=%b/%0h want %b/%0h", i, got_last[i], got_data[i], (i == 3), mem[8'(b + i)]);
         else n_pass++;
      end
   endtask

   task automatic test_zero_and_restart();
      logic [AW-1:0] b;
      run_burst(8'd77, 0, 0, -1);
      n_checks++;
      if (done_count != 1 || done_k < 0 || done_k > 1) $display("FAIL zero_done: count=%0d cycle=%0d want 1 pulse by cycle 1", done_count, done_k);
      else n_pass++;
      n_checks++;
      if (got_addr.size() != 0 || first_valid_k != -1)
         $display("FAIL zero_activity: strobes=%0d first_valid=%0d want 0/-1", got_addr.size(), first_valid_k);
      else n_pass++;
      b = 8'd100;
      run_burst(b, 6, 0, 3);
      n_checks++;
      if (got_data.size() != 6 || got_addr.size() != 6 || done_count != 1)
         $display("FAIL restart_counts: beats=%0d strobes=%0d dones=%0d want 6/6/1", got_data.size(), got_addr.size(), done_count);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if ({got_addr[i], got_last[i], got_data[i]} !== {8'(b + i), (i == 5), mem[8'(b + i)]})
            $display("FAIL restart_beat%0d: addr/last/data=%0d/%b/%0h want %0d/%b/%0h", i, got_addr[i], got_last[i], got_data[i],
                     8'(b + i), (i == 5), mem[8'(b + i)]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midburst();
      int spurious;
      base_address = 8'd40; length = LW'(8); stream_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      n_checks++;
      if ({busy, stream_valid, ram_output_enable} !== 3'b110)
         $display("FAIL midrst_pre: busy/valid/strobe=%b want 110", {busy, stream_valid, ram_output_enable});
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last} !== '0)
         $display("FAIL midrst_clear: outputs=%0h want 0",
                  {busy, done, ram_output_enable, ram_address, stream_data, stream_valid, stream_last});
      else n_pass++;
      @(posedge clk); #1 reset = 1'b0;
      #1;
      spurious = 0;
      for (int i = 0; i < 5; i++) begin
         if (done || busy || stream_valid || ram_output_enable) spurious++;
         @(posedge clk); #2;
      end
      n_checks++;
      if (spurious != 0) $display("FAIL midrst_quiet: active cycles=%0d want 0", spurious); else n_pass++;
      test_basic("after_reset");
   endtask

   task automatic test_random();
      logic [AW-1:0] b;
      int len, bad;
      for (int n = 0; n < 9; n++) begin
         b   = 8'($urandom);
         len = (n == 8) ? 256 : int'($urandom_range(1, 12));
         run_burst(b, len, 2, -1);
         n_checks++;
         if (got_data.size() != len || got_addr.size() != len || done_count != 1 || timed_out != 0)
            $display("FAIL rand%0d_counts: beats=%0d strobes=%0d dones=%0d timeout=%0d want %0d/%0d/1/0",
                     n, got_data.size(), got_addr.size(), done_count, timed_out, len, len);
         else n_pass++;
         bad = 0;
         for (int i = 0; i < len; i++) begin
            if ({got_addr[i], got_last[i], got_data[i]} !== {8'(b + i), (i == len - 1), mem[8'(b + i)]}) bad++;
         end
         n_checks++;
         if (bad != 0) $display("FAIL rand%0d_beats: wrong beats=%0d want 0 (base %0d len %0d)", n, bad, b, len);
         else n_pass++;
         n_checks++;
         if (stall_changes != 0 || max_ahead > 2)
            $display("FAIL rand%0d_flow: stall changes=%0d ahead=%0d want 0/<=2", n, stall_changes, max_ahead);
         else n_pass++;
      end
      n_checks++;
      if (got_addr[255] !== 8'(b - 1)) $display("FAIL full_last_addr: got %0d want %0d", got_addr[255], 8'(b - 1));
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) mem[40 + i] = 8'(8'hA0 + i);
      test_reset();
      test_basic("basic");
      test_backpressure();
      test_wrap();
      test_zero_and_restart();
      test_reset_midburst();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
